// File: rtl/sap2_acc_alu_breg_if.sv
// W-bus side signal bundle for the SAP-2 accumulator/B/ALU slice.
// The controller/bus side uses master, the arithmetic slice uses slave.
interface sap2_acc_alu_breg_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] bus_in;
  logic             n_la;
  logic             ea;
  logic             n_lb;
  logic             eb;
  logic [3:0]       sel;
  logic             eu;
  logic [WIDTH-1:0] acc_bus;
  logic [WIDTH-1:0] b_bus;
  logic [WIDTH-1:0] alu_bus;
  logic [WIDTH-1:0] acc_alu;
  logic [1:0]       flags;

  modport master (
    output bus_in, n_la, ea, n_lb, eb, sel, eu,
    input  acc_bus, b_bus, alu_bus, acc_alu, flags
  );

  modport slave (
    input  bus_in, n_la, ea, n_lb, eb, sel, eu,
    output acc_bus, b_bus, alu_bus, acc_alu, flags
  );
endinterface

// File: rtl/sap2_acc_alu_breg.sv
// SAP-2 arithmetic slice: accumulator A, B register, 16-op combinational ALU
// and registered {sign, zero} flags. Each source drives its own gated bus output.
module sap2_acc_alu_breg #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  sap2_acc_alu_breg_if.slave bus
);

  typedef enum logic [3:0] {
    OP_ADD   = 4'b0000,
    OP_SUB   = 4'b0001,
    OP_AND   = 4'b0010,
    OP_OR    = 4'b0011,
    OP_XOR   = 4'b0100,
    OP_NOT   = 4'b0101,
    OP_RAL   = 4'b0110,
    OP_RAR   = 4'b0111,
    OP_INCA  = 4'b1000,
    OP_DECA  = 4'b1001,
    OP_INCB  = 4'b1010,
    OP_DECB  = 4'b1011,
    OP_PASSA = 4'b1100,
    OP_PASSB = 4'b1101,
    OP_ZERO  = 4'b1110,
    OP_ONES  = 4'b1111
  } alu_op_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] breg;
  logic [WIDTH-1:0] result;
  logic             flag_s;
  logic             flag_z;
  alu_op_t          op;

  assign op = alu_op_t'(bus.sel);

  // Accumulator: loads only from the W bus; ALU feedback goes through the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (!bus.n_la) begin
      acc <= bus.bus_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      breg <= '0;
    end else if (!bus.n_lb) begin
      breg <= bus.bus_in;
    end
  end

  // All arithmetic wraps at WIDTH bits; there is no carry out.
  always_comb begin
    result = '0;
    case (op)
      OP_ADD:   result = acc + breg;
      OP_SUB:   result = acc - breg;
      OP_AND:   result = acc & breg;
      OP_OR:    result = acc | breg;
      OP_XOR:   result = acc ^ breg;
      OP_NOT:   result = ~acc;
      OP_RAL:   result = {acc[WIDTH-2:0], acc[WIDTH-1]};
      OP_RAR:   result = {acc[0], acc[WIDTH-1:1]};
      OP_INCA:  result = acc + ONE;
      OP_DECA:  result = acc - ONE;
      OP_INCB:  result = breg + ONE;
      OP_DECB:  result = breg - ONE;
      OP_PASSA: result = acc;
      OP_PASSB: result = breg;
      OP_ZERO:  result = '0;
      OP_ONES:  result = '1;
      default:  result = '0;
    endcase
  end

  // Flags sample the result only when the ALU is driving the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_s <= 1'b0;
      flag_z <= 1'b0;
    end else if (bus.eu) begin
      flag_s <= result[WIDTH-1];
      flag_z <= (result == '0);
    end
  end

  // Disabled sources drive zero so the top-level mux can OR them together.
  assign bus.acc_bus = bus.ea ? acc    : '0;
  assign bus.b_bus   = bus.eb ? breg   : '0;
  assign bus.alu_bus = bus.eu ? result : '0;
  assign bus.acc_alu = acc;
  assign bus.flags   = {flag_s, flag_z};

endmodule

// File: tb/tb_sap2_acc_alu_breg.sv
// Scoreboard bench for sap2_acc_alu_breg: expected values are queued as
// stimulus is applied and compared when the DUT outputs are sampled.
module tb_sap2_acc_alu_breg;

  logic clk;
  logic rst;

  sap2_acc_alu_breg_if #(.WIDTH(8)) ifc ();

  sap2_acc_alu_breg #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int F_ACC_BUS = 0;
  localparam int F_B_BUS   = 1;
  localparam int F_ALU_BUS = 2;
  localparam int F_ACC_ALU = 3;
  localparam int F_FLAGS   = 4;

  typedef struct {
    string      tag;
    int         field;
    logic [7:0] value;
  } exp_t;

  exp_t sb[$];
  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] m_a, m_b;
  logic [1:0] m_flags;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] observe(input int field);
    case (field)
      F_ACC_BUS: return ifc.acc_bus;
      F_B_BUS:   return ifc.b_bus;
      F_ALU_BUS: return ifc.alu_bus;
      F_ACC_ALU: return ifc.acc_alu;
      default:   return {6'b0, ifc.flags};
    endcase
  endfunction

  function automatic logic [7:0] alu_ref(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b);
    case (s)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a & b;
      4'h3: return a | b;
      4'h4: return a ^ b;
      4'h5: return ~a;
      4'h6: return {a[6:0], a[7]};
      4'h7: return {a[0], a[7:1]};
      4'h8: return a + 8'd1;
      4'h9: return a - 8'd1;
      4'hA: return b + 8'd1;
      4'hB: return b - 8'd1;
      4'hC: return a;
      4'hD: return b;
      4'hE: return 8'h00;
      default: return 8'hFF;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int field, input logic [7:0] value);
    exp_t e;
    e.tag = tag;
    e.field = field;
    e.value = value;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.field), e.value);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ab(input logic [7:0] a, input logic [7:0] b);
    ifc.eu = 1'b0;
    ifc.bus_in = a; ifc.n_la = 1'b0; ifc.n_lb = 1'b1;
    tick();
    ifc.bus_in = b; ifc.n_la = 1'b1; ifc.n_lb = 1'b0;
    tick();
    ifc.n_lb = 1'b1;
    m_a = a;
    m_b = b;
  endtask

  // Apply an ALU op with eu=1, check the combinational result, then the flags after the edge.
  task automatic alu_op(input string tag, input logic [3:0] s, input logic [7:0] exp_r, input logic [1:0] exp_f);
    ifc.sel = s;
    ifc.eu = 1'b1;
    #1;
    expect_val({tag, "_alu"}, F_ALU_BUS, exp_r);
    drain();
    tick();
    expect_val({tag, "_flags"}, F_FLAGS, {6'b0, exp_f});
    drain();
    ifc.eu = 1'b0;
    m_flags = exp_f;
  endtask

  initial begin
    logic [7:0] ra, rb, rr;
    logic [3:0] rs;

    rst = 1'b1;
    ifc.bus_in = 8'hA5;
    ifc.n_la = 1'b0; ifc.n_lb = 1'b0;
    ifc.ea = 1'b1; ifc.eb = 1'b1; ifc.eu = 1'b0;
    ifc.sel = 4'h0;
    m_a = 0; m_b = 0; m_flags = 0;
    repeat (2) tick();
    expect_val("reset_acc_bus", F_ACC_BUS, 8'h00);
    expect_val("reset_b_bus",   F_B_BUS,   8'h00);
    expect_val("reset_acc_alu", F_ACC_ALU, 8'h00);
    expect_val("reset_flags",   F_FLAGS,   8'h00);
    drain();
    rst = 1'b0;
    ifc.n_la = 1'b1; ifc.n_lb = 1'b1;
    tick();

    // Asynchronous clear mid-cycle while a load is pending
    load_ab(8'h80, 8'h33);
    alu_op("pre_clr", 4'hC, 8'h80, 2'b10);
    ifc.bus_in = 8'h55; ifc.n_la = 1'b0; ifc.eu = 1'b1;
    #2 rst = 1'b1;
    #1;
    expect_val("clr_async_acc",   F_ACC_ALU, 8'h00);
    expect_val("clr_async_b",     F_B_BUS,   8'h00);
    expect_val("clr_async_flags", F_FLAGS,   8'h00);
    drain();
    tick();
    expect_val("clr_hold_acc",   F_ACC_ALU, 8'h00);
    expect_val("clr_hold_flags", F_FLAGS,   8'h00);
    drain();
    rst = 1'b0; ifc.n_la = 1'b1; ifc.eu = 1'b0;
    m_a = 0; m_b = 0; m_flags = 0;
    tick();

    // ADD
    load_ab(8'h3C, 8'h05);
    expect_val("load_acc_bus", F_ACC_BUS, 8'h3C);
    expect_val("load_b_bus",   F_B_BUS,   8'h05);
    drain();
    alu_op("add", 4'h0, 8'h41, 2'b00);

    // SUB to zero, then A-1 wrap
    load_ab(8'h05, 8'h05);
    alu_op("sub_zero", 4'h1, 8'h00, 2'b01);
    load_ab(8'h00, 8'h05);
    alu_op("deca_wrap", 4'h9, 8'hFF, 2'b10);

    // Rotates and NOT
    load_ab(8'h81, 8'h00);
    alu_op("ral", 4'h6, 8'h03, 2'b00);
    alu_op("rar", 4'h7, 8'hC0, 2'b10);
    alu_op("not", 4'h5, 8'h7E, 2'b00);

    // ALU feedback through the W bus: A=FF, A+1 written back
    load_ab(8'hFF, 8'h00);
    ifc.sel = 4'h8; ifc.eu = 1'b1; ifc.n_la = 1'b0;
    #1;
    ifc.bus_in = ifc.alu_bus;
    expect_val("fb_alu", F_ALU_BUS, 8'h00);
    drain();
    tick();
    expect_val("fb_acc",   F_ACC_ALU, 8'h00);
    expect_val("fb_flags", F_FLAGS,   8'h01);
    drain();
    ifc.n_la = 1'b1; ifc.eu = 1'b0;
    m_a = 8'h00; m_flags = 2'b01;

    // Gating and hold with changing bus_in and unknown sel
    load_ab(8'h6D, 8'h92);
    ifc.ea = 1'b0; ifc.eb = 1'b0; ifc.eu = 1'b0;
    ifc.sel = 4'bxxxx;
    #1;
    expect_val("gate_acc_bus", F_ACC_BUS, 8'h00);
    expect_val("gate_b_bus",   F_B_BUS,   8'h00);
    expect_val("gate_alu_bus", F_ALU_BUS, 8'h00);
    drain();
    for (int i = 0; i < 10; i++) begin
      ifc.bus_in = 8'($urandom);
      tick();
      expect_val("hold_acc",   F_ACC_ALU, 8'h6D);
      expect_val("hold_flags", F_FLAGS,   {6'b0, m_flags});
      drain();
    end
    ifc.eb = 1'b1;
    #1;
    expect_val("hold_b", F_B_BUS, 8'h92);
    drain();
    ifc.ea = 1'b1;

    // Random operand/op sweep against the reference ALU
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 4'($urandom_range(0, 15));
      if (i == 0) begin ra = 8'hFF; rb = 8'h01; rs = 4'h0; end
      load_ab(ra, rb);
      rr = alu_ref(rs, ra, rb);
      expect_val("rnd_acc_bus", F_ACC_BUS, ra);
      expect_val("rnd_b_bus",   F_B_BUS,   rb);
      drain();
      alu_op("rnd", rs, rr, {rr[7], (rr == 8'h00)});
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
